// File: rtl/regfile_writeback_arbiter.sv
// Shares the register file write port between the ALU and load writeback paths.
// Each source has a one-entry buffer; a round-robin arbiter drains them into a registered write stage.
module regfile_writeback_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter bit PRIORITY_MEM = 1'b1
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic [ADDR_WIDTH-1:0] Rs,
  input  logic [ADDR_WIDTH-1:0] Rt,
  output logic                  rs_pending,
  output logic                  rt_pending,
  output logic                  WENREG,
  output logic [ADDR_WIDTH-1:0] Rd,
  output logic [DATA_WIDTH-1:0] RdDATA,
  output logic                  busy
);

  logic                  buf_alu_valid;
  logic [ADDR_WIDTH-1:0] buf_alu_rd;
  logic [DATA_WIDTH-1:0] buf_alu_data;
  logic                  buf_mem_valid;
  logic [ADDR_WIDTH-1:0] buf_mem_rd;
  logic [DATA_WIDTH-1:0] buf_mem_data;

  // last_mem = 1 when the memory source holds the most recent grant
  logic last_mem;
  logic grant_alu;
  logic grant_mem;
  logic alu_accept;
  logic mem_accept;

  assign grant_alu = buf_alu_valid && (!buf_mem_valid || last_mem);
  assign grant_mem = buf_mem_valid && (!buf_alu_valid || !last_mem);

  assign alu_ready = !RESET && (!buf_alu_valid || grant_alu);
  assign mem_ready = !RESET && (!buf_mem_valid || grant_mem);

  assign alu_accept = alu_valid && alu_ready;
  assign mem_accept = mem_valid && mem_ready;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      buf_alu_valid <= 1'b0;
      buf_alu_rd    <= '0;
      buf_alu_data  <= '0;
    end else if (alu_accept) begin
      buf_alu_valid <= 1'b1;
      buf_alu_rd    <= alu_rd;
      buf_alu_data  <= alu_data;
    end else if (grant_alu) begin
      buf_alu_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      buf_mem_valid <= 1'b0;
      buf_mem_rd    <= '0;
      buf_mem_data  <= '0;
    end else if (mem_accept) begin
      buf_mem_valid <= 1'b1;
      buf_mem_rd    <= mem_rd;
      buf_mem_data  <= mem_data;
    end else if (grant_mem) begin
      buf_mem_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      last_mem <= ~PRIORITY_MEM;
    end else if (grant_alu) begin
      last_mem <= 1'b0;
    end else if (grant_mem) begin
      last_mem <= 1'b1;
    end
  end

  // rd = 0 is drained like any other entry but never raises the write enable
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      WENREG <= 1'b0;
      Rd     <= '0;
      RdDATA <= '0;
    end else if (grant_alu) begin
      WENREG <= |buf_alu_rd;
      Rd     <= buf_alu_rd;
      RdDATA <= buf_alu_data;
    end else if (grant_mem) begin
      WENREG <= |buf_mem_rd;
      Rd     <= buf_mem_rd;
      RdDATA <= buf_mem_data;
    end else begin
      WENREG <= 1'b0;
    end
  end

  assign rs_pending = (Rs != '0) &&
                      ((buf_alu_valid && (buf_alu_rd == Rs)) ||
                       (buf_mem_valid && (buf_mem_rd == Rs)) ||
                       (WENREG && (Rd == Rs)));

  assign rt_pending = (Rt != '0) &&
                      ((buf_alu_valid && (buf_alu_rd == Rt)) ||
                       (buf_mem_valid && (buf_mem_rd == Rt)) ||
                       (WENREG && (Rd == Rt)));

  assign busy = buf_alu_valid || buf_mem_valid || WENREG;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter with hand-computed expectations.
module tb_regfile_writeback_arbiter;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic [4:0]  Rs = '0;
  logic [4:0]  Rt = '0;
  logic        rs_pending;
  logic        rt_pending;
  logic        WENREG;
  logic [4:0]  Rd;
  logic [31:0] RdDATA;
  logic        busy;

  int checks = 0;
  int errors = 0;

  regfile_writeback_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .PRIORITY_MEM(1'b1)
  ) dut (
    .clk(clk), .RESET(RESET),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .Rs(Rs), .Rt(Rt), .rs_pending(rs_pending), .rt_pending(rt_pending),
    .WENREG(WENREG), .Rd(Rd), .RdDATA(RdDATA), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 RESET = 1'b1;
    #1;
    check("rst_wen", {31'd0, WENREG}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rdy", {30'd0, alu_ready, mem_ready}, 32'd0);
    step();
    #2 RESET = 1'b0;
    step();
  endtask

  initial begin
    logic [1:0] ai;
    logic [1:0] mi;
    logic       a_acc;
    logic       m_acc;

    // Reset then idle
    #7;
    check("rst_wen0", {31'd0, WENREG}, 32'd0);
    check("rst_rd0", {27'd0, Rd}, 32'd0);
    check("rst_data0", RdDATA, 32'd0);
    check("rst_busy0", {31'd0, busy}, 32'd0);
    check("rst_rdy0", {30'd0, alu_ready, mem_ready}, 32'd0);
    step();
    RESET = 1'b0;
    #1;
    check("idle_rdy", {30'd0, alu_ready, mem_ready}, 32'd3);
    step();

    // Single ALU write
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'd49; Rs = 5'd2; Rt = 5'd9;
    step();
    alu_valid = 1'b0;
    check("alu_pend_buf", {30'd0, rs_pending, rt_pending}, 32'd2);
    check("alu_wen_n", {31'd0, WENREG}, 32'd0);
    check("alu_busy_n", {31'd0, busy}, 32'd1);
    step();
    check("alu_wen", {31'd0, WENREG}, 32'd1);
    check("alu_rd", {27'd0, Rd}, 32'd2);
    check("alu_data", RdDATA, 32'd49);
    check("alu_pend_ws", {31'd0, rs_pending}, 32'd1);
    step();
    check("alu_wen_drop", {31'd0, WENREG}, 32'd0);
    check("alu_pend_clr", {31'd0, rs_pending}, 32'd0);
    check("alu_busy_clr", {31'd0, busy}, 32'd0);
    check("alu_rd_hold", {27'd0, Rd}, 32'd2);

    // Contention after reset: memory wins first
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'd38025;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'd7;
    Rs = 5'd3; Rt = 5'd4;
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("cont_rdy", {30'd0, alu_ready, mem_ready}, 32'd1);
    check("cont_pend", {30'd0, rs_pending, rt_pending}, 32'd3);
    step();
    check("cont_w1_wen", {31'd0, WENREG}, 32'd1);
    check("cont_w1_rd", {27'd0, Rd}, 32'd4);
    check("cont_w1_data", RdDATA, 32'd7);
    check("cont_rdy2", {30'd0, alu_ready, mem_ready}, 32'd3);
    step();
    check("cont_w2_wen", {31'd0, WENREG}, 32'd1);
    check("cont_w2_rd", {27'd0, Rd}, 32'd3);
    check("cont_w2_data", RdDATA, 32'd38025);
    check("cont_w2_pend", {30'd0, rs_pending, rt_pending}, 32'd2);
    step();
    check("cont_idle", {31'd0, busy}, 32'd0);

    // Streaming: three entries per source; last grant was ALU so MEM leads
    ai = 2'd0; mi = 2'd0;
    alu_rd = 5'd6; mem_rd = 5'd7;
    for (int k = 0; k < 8; k++) begin
      alu_valid = (ai < 2'd3); alu_data = 32'h100 + 32'(ai);
      mem_valid = (mi < 2'd3); mem_data = 32'h200 + 32'(mi);
      a_acc = alu_valid && alu_ready;
      m_acc = mem_valid && mem_ready;
      step();
      if (a_acc) ai++;
      if (m_acc) mi++;
      if (k >= 1 && k <= 6) begin
        check("strm_wen", {31'd0, WENREG}, 32'd1);
        if (k % 2 == 1) begin
          check("strm_rd_mem", {27'd0, Rd}, 32'd7);
          check("strm_data_mem", RdDATA, 32'h200 + 32'((k - 1) / 2));
        end else begin
          check("strm_rd_alu", {27'd0, Rd}, 32'd6);
          check("strm_data_alu", RdDATA, 32'h100 + 32'(k / 2 - 1));
        end
      end else if (k == 7) begin
        check("strm_end_wen", {31'd0, WENREG}, 32'd0);
        check("strm_end_busy", {31'd0, busy}, 32'd0);
      end
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("strm_cnt", {28'd0, ai, mi}, 32'hF);

    // Zero register
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFF_FFFF; Rs = 5'd0; Rt = 5'd0;
    step();
    mem_valid = 1'b0;
    check("zero_pend", {30'd0, rs_pending, rt_pending}, 32'd0);
    check("zero_busy_n", {31'd0, busy}, 32'd1);
    step();
    check("zero_wen", {31'd0, WENREG}, 32'd0);
    check("zero_data", RdDATA, 32'hFFFF_FFFF);
    check("zero_busy", {31'd0, busy}, 32'd0);
    check("zero_rdy", {31'd0, mem_ready}, 32'd1);

    // Reset mid-operation discards both buffers
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'd1;
    mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 32'd2;
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("mid_busy_pre", {31'd0, busy}, 32'd1);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      check("mid_wen", {31'd0, WENREG}, 32'd0);
      check("mid_busy", {31'd0, busy}, 32'd0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
